// File: rtl/irq_ctl_multi.sv
// irq_ctl_multi: multi-source interrupt controller for the CPU I/O bus.
// Up to 16 sources, each with its own enable and edge/level mode, software
// set/clear of pending bits, and a lowest-index-first priority vector.
// Optional build macro: IRQ_CTL_MULTI_SYNC_EN inserts a 2-flop synchroniser
// per source ahead of edge detection (adds 2 cycles of input latency).
//
// Bus handshake: a register write is a single-cycle wr pulse with addr/din
// valid in that cycle; reads are combinational from addr, no strobe.
module irq_ctl_multi #(
    parameter int NUM_IRQ = 15,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NUM_IRQ-1:0] irqs_in,
    input  logic               wr,
    input  logic [1:0]         addr,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  dout,
    output logic               irq_assert
);

    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_ENABLE  = 2'd1;
    localparam logic [1:0] A_MODE    = 2'd2;
    localparam logic [1:0] A_VECTOR  = 2'd3;

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_prev;
    logic               r_irq;

    logic [NUM_IRQ-1:0] w_s;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_hw_set;
    logic [NUM_IRQ-1:0] w_sw_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_din;
    logic [NUM_IRQ-1:0] w_active;
    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_vector;
    logic               w_unused_din;

`ifdef IRQ_CTL_MULTI_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    // Two-flop synchroniser for sources outside the clk domain.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irqs_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = irqs_in;
`endif

    // Bits of din above NUM_IRQ have no register behind them.
    assign w_din        = din[NUM_IRQ-1:0];
    assign w_unused_din = ^din;

    assign w_edge   = w_s & ~r_prev;
    assign w_hw_set = (r_mode & w_edge) | (~r_mode & w_s);
    assign w_sw_set = (wr && addr == A_VECTOR)  ? w_din : '0;
    assign w_clr    = (wr && addr == A_PENDING) ? w_din : '0;
    assign w_active = r_pending & r_enable;

    // Register state: prev/pending every cycle, enable/mode on writes.
    // Sets are OR-ed in after the clear so a same-cycle set always wins.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_mode    <= '1;
            r_prev    <= w_s;
            r_irq     <= 1'b0;
        end else begin
            r_prev    <= w_s;
            r_pending <= (r_pending & ~w_clr) | w_hw_set | w_sw_set;
            r_irq     <= |w_active;
            if (wr && addr == A_ENABLE) begin
                r_enable <= w_din;
            end
            if (wr && addr == A_MODE) begin
                r_mode <= w_din;
            end
        end
    end

    // Priority encoder: scanning high to low leaves the lowest active index.
    always_comb begin
        w_valid = 1'b0;
        w_idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_valid = 1'b1;
                w_idx   = IDX_W'(i);
            end
        end
    end

    // Vector word: valid flag in the top bit, index in the low bits.
    always_comb begin
        w_vector               = '0;
        w_vector[DATA_W-1]     = w_valid;
        w_vector[IDX_W-1:0]    = w_valid ? w_idx : '0;
    end

    // Read mux; unimplemented upper bits are zero-extended.
    always_comb begin
        dout = '0;
        case (addr)
            A_PENDING: dout = DATA_W'(r_pending);
            A_ENABLE:  dout = DATA_W'(r_enable);
            A_MODE:    dout = DATA_W'(r_mode);
            A_VECTOR:  dout = w_vector;
            default:   dout = '0;
        endcase
    end

    assign irq_assert = r_irq;

endmodule

// File: tb/tb_irq_ctl_multi.sv
// Testbench for irq_ctl_multi (default parameters, NUM_IRQ=15).
// Inputs are driven just after the falling edge; outputs are read there too.
module tb_irq_ctl_multi;

    localparam int N = 15;
    localparam int W = 16;
`ifdef IRQ_CTL_MULTI_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    localparam logic [W-1:0] MASK = 16'h7FFF;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         nreset;
    logic [N-1:0] irqs_in;
    logic         wr;
    logic [1:0]   addr;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         irq_assert;

    always #5 clk = ~clk;

    irq_ctl_multi dut (
        .clk        (clk),
        .nreset     (nreset),
        .irqs_in    (irqs_in),
        .wr         (wr),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .irq_assert (irq_assert)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input logic [W-1:0] e);
        exp_q.push_back(e);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a);
        logic [W-1:0] e;
        addr = a;
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_noexp"}, dout, 16'hxxxx);
        end else begin
            e = exp_q.pop_front();
            chk(tag, dout, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [W-1:0] d);
        wr   = 1'b1;
        addr = a;
        din  = d;
        @(negedge clk);
        wr   = 1'b0;
    endtask

    function automatic logic [W-1:0] vec_of(input logic [W-1:0] act);
        vec_of = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (act[i]) vec_of = 16'h8000 | W'(i);
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rst_pend;
        logic [W-1:0] m_pend, m_en, p_pend, p_en, d;
        int op;

        // Reset with source 0 held high; only the synchronised build sees
        // an edge afterwards, because its prev loads the synchroniser output.
        rst_pend = (L > 0) ? 16'h0001 : 16'h0000;
        nreset  = 1'b0;
        irqs_in = 15'h0001;
        wr      = 1'b0;
        addr    = 2'd0;
        din     = '0;
        repeat (3) cyc();
        nreset = 1'b1;
        wr_reg(2'd1, 16'h0001);
        repeat (3) cyc();
        expect_val(rst_pend);  rd_chk("rst_pend", 2'd0);
        chk("rst_irq", {15'b0, irq_assert}, rst_pend);
        expect_val(16'h0001);  rd_chk("rst_en", 2'd1);
        expect_val(MASK);      rd_chk("rst_mode", 2'd2);
        irqs_in = '0;
        repeat (L + 2) cyc();
        wr_reg(2'd0, 16'hFFFF);
        cyc();
        chk("rst_clr_irq", {15'b0, irq_assert}, 16'h0000);
        expect_val(16'h0000);  rd_chk("rst_clr_vec", 2'd3);

        // Edge source: one-cycle pulse on bit 0.
        irqs_in = 15'h0001;
        for (int k = 1; k <= 2 + L; k++) begin
            cyc();
            if (k == 1) irqs_in = '0;
            if (k == 1 + L) begin
                expect_val(16'h0001); rd_chk("edge_pend", 2'd0);
            end
            chk("edge_irq", {15'b0, irq_assert}, (k == 2 + L) ? 16'h1 : 16'h0);
        end
        wr_reg(2'd0, 16'h0001);
        expect_val(16'h0000);  rd_chk("edge_clr_pend", 2'd0);
        chk("edge_clr_irq1", {15'b0, irq_assert}, 16'h1);
        cyc();
        chk("edge_clr_irq2", {15'b0, irq_assert}, 16'h0);

        // Level source on bit 2.
        wr_reg(2'd2, 16'h0000);
        wr_reg(2'd1, 16'h0004);
        irqs_in = 15'h0004;
        repeat (L + 3) cyc();
        wr_reg(2'd0, 16'h0004);
        expect_val(16'h0004);  rd_chk("lvl_hold_pend", 2'd0);
        chk("lvl_hold_irq", {15'b0, irq_assert}, 16'h1);
        irqs_in = '0;
        repeat (L + 2) cyc();
        wr_reg(2'd0, 16'h0004);
        expect_val(16'h0000);  rd_chk("lvl_drop_pend", 2'd0);
        cyc();
        chk("lvl_drop_irq", {15'b0, irq_assert}, 16'h0);
        // Level to edge while held high: no edge results.
        irqs_in = 15'h0004;
        repeat (L + 2) cyc();
        wr_reg(2'd2, 16'hFFFF);
        wr_reg(2'd0, 16'h0004);
        expect_val(16'h0000);  rd_chk("lvl2edge_pend", 2'd0);
        irqs_in = '0;
        repeat (L + 2) cyc();
        expect_val(16'h0000);  rd_chk("lvl2edge_pend2", 2'd0);

        // Priority.
        wr_reg(2'd1, 16'h0020);
        wr_reg(2'd3, 16'h0028);
        expect_val(16'h0028);  rd_chk("prio_pend", 2'd0);
        expect_val(16'h8005);  rd_chk("prio_vec5", 2'd3);
        wr_reg(2'd1, 16'h0028);
        expect_val(16'h8003);  rd_chk("prio_vec3", 2'd3);
        wr_reg(2'd0, 16'hFFFF);
        expect_val(16'h0000);  rd_chk("prio_vec0", 2'd3);
        cyc();
        chk("prio_irq0", {15'b0, irq_assert}, 16'h0);

        // Collision: clear on the same cycle bit 1's edge is detected.
        wr_reg(2'd1, 16'h0002);
        irqs_in = 15'h0002;
        repeat (L) cyc();
        wr_reg(2'd0, 16'h0002);
        expect_val(16'h0002);  rd_chk("collide_pend", 2'd0);
        irqs_in = '0;
        repeat (L + 1) cyc();
        wr_reg(2'd0, 16'hFFFF);
        expect_val(16'h0000);  rd_chk("collide_clr", 2'd0);

        // Masking and width.
        wr_reg(2'd1, 16'h0000);
        wr_reg(2'd3, 16'hFFFF);
        expect_val(MASK);      rd_chk("width_pend", 2'd0);
        cyc();
        chk("mask_irq0", {15'b0, irq_assert}, 16'h0);
        wr_reg(2'd1, 16'hFFFF);
        chk("en_lag_irq", {15'b0, irq_assert}, 16'h0);
        expect_val(MASK);      rd_chk("width_en", 2'd1);
        cyc();
        chk("en_irq1", {15'b0, irq_assert}, 16'h1);
        expect_val(16'h8000);  rd_chk("width_vec", 2'd3);
        wr_reg(2'd1, 16'h0000);
        expect_val(MASK);      rd_chk("mask_pend_kept", 2'd0);
        cyc();
        chk("mask_irq_off", {15'b0, irq_assert}, 16'h0);

        // Reset mid-operation with a write pending on the bus.
        wr_reg(2'd1, 16'hFFFF);
        wr_reg(2'd2, 16'h0000);
        nreset = 1'b0;
        wr     = 1'b1;
        addr   = 2'd3;
        din    = 16'hFFFF;
        cyc();
        nreset = 1'b1;
        wr     = 1'b0;
        expect_val(16'h0000);  rd_chk("mid_rst_pend", 2'd0);
        expect_val(16'h0000);  rd_chk("mid_rst_en", 2'd1);
        expect_val(MASK);      rd_chk("mid_rst_mode", 2'd2);
        chk("mid_rst_irq", {15'b0, irq_assert}, 16'h0);

        // Random software set / clear / enable traffic.
        m_pend = '0;
        m_en   = '0;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            d  = W'($urandom_range(0, 16'hFFFF));
            p_pend = m_pend;
            p_en   = m_en;
            if (op == 0) begin
                m_pend = m_pend & ~d;
                wr_reg(2'd0, d);
            end else if (op == 1) begin
                m_pend = (m_pend | d) & MASK;
                wr_reg(2'd3, d);
            end else begin
                m_en = d & MASK;
                wr_reg(2'd1, d);
            end
            expect_val(m_pend);               rd_chk("rnd_pend", 2'd0);
            expect_val(vec_of(m_pend & m_en)); rd_chk("rnd_vec", 2'd3);
            chk("rnd_irq", {15'b0, irq_assert}, {15'b0, |(p_pend & p_en)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
